sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between the instruction-fetch requester (IF) and the data-access requester (MEM stage).
- Applies a fixed data-first priority, with a starvation guard that forces an IF grant after a bounded number of consecutive data wins.
- Performs one SRAM access per cycle with 1-cycle read latency, and tags each read response back to its requester.
- Sits between the IF/MEM stage SRAM interfaces and the unified RAM.

Parameters:
STARVE_LIMIT, 4, consecutive cycles IF may lose to MEM before IF gets forced priority (legal range 1..15)
CNT_W, 4, width of the starvation counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  IF read request; held high until if_gnt
if_addr  in  32  IF byte address (word read)
if_kill  in  1  IF redirect: drops the IF response due this cycle and blocks any IF grant this cycle
if_gnt  out  1  IF request accepted this cycle (combinational)
if_rvalid  out  1  IF read data valid this cycle
if_rdata  out  32  IF read data, meaningful only while if_rvalid
mem_req  in  1  MEM request; held stable until mem_gnt
mem_we  in  1  1 = write, 0 = read
mem_addr  in  32  MEM byte address
mem_wdata  in  32  MEM write data
mem_mode  in  3  access size code, passed through to RAM
mem_us  in  1  unsigned-load flag, passed through to RAM
mem_gnt  out  1  MEM request accepted this cycle (combinational)
mem_rvalid  out  1  MEM read data valid this cycle (reads only)
mem_rdata  out  32  MEM read data, meaningful only while mem_rvalid
ram_en  out  1  SRAM enable
ram_we  out  1  SRAM write enable
ram_addr  out  32  SRAM address
ram_wdata  out  32  SRAM write data
ram_mode  out  3  SRAM access size
ram_us  out  1  SRAM unsigned flag
ram_rdata  in  32  SRAM read data, valid the cycle after a read enable

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to PRI_MEM; starvation counter cleared; response tag cleared.
  - if_gnt, mem_gnt, if_rvalid, mem_rvalid, ram_en and ram_we are 0.
  - All data outputs are 0.
- Reset deassertion:
  - Grants may assert in the first cycle after deassertion.
  - A response in flight when reset asserts is discarded and never reported.
- FSM states: PRI_MEM (MEM wins conflicts) and PRI_IF (IF wins conflicts).
- Grant logic, combinational, at most one grant per cycle:
  - Eligible IF = if_req & ~if_kill.
  - Only one side eligible: that side is granted.
  - Both eligible: the state's priority side is granted.
- RAM drive in the grant cycle:
  - ram_en = 1 for the granted request.
  - ram_we = mem_we only on a MEM grant; 0 on an IF grant.
  - On an IF grant: ram_mode = word code (3'b010), ram_us = 0.
  - With no grant, ram_en = 0 and ram_we = 0.
- Response:
  - Registered tag {valid, owner} is set on a read grant.
  - In cycle N+1, the owner's rvalid = 1 and its rdata = ram_rdata (pass-through, not held).
  - MEM writes produce no rvalid.
  - if_kill high in cycle N+1 forces if_rvalid = 0.
  - Back-to-back grants give back-to-back responses (throughput 1/cycle).
- Starvation counter:
  - Increments on each cycle with eligible IF and a MEM grant.
  - Clears on any IF grant or any cycle where IF is not eligible.
  - Saturates at STARVE_LIMIT.
- Transitions:
  - PRI_MEM to PRI_IF when the counter reaches STARVE_LIMIT; the next eligible IF is granted regardless of mem_req.
  - PRI_IF to PRI_MEM on an IF grant or when IF is not eligible; the counter clears.
- Simultaneous events:
  - if_kill with mem_req: MEM is granted even in PRI_IF; the state then returns to PRI_MEM.
  - No request: the FSM holds its state, except PRI_IF, which returns as above.
- Requesters must hold addr/data stable while req=1 and gnt=0; the arbiter does not latch request fields.

Test Plan:
- After reset release, if_req=1, if_addr=0x100, mem_req=0 -> if_gnt=1 and ram_en=1, ram_addr=0x100, ram_we=0 the same cycle; next cycle if_rvalid=1, if_rdata=RAM[0x100], mem_rvalid=0.
- Both requesting, mem_we=0, mem_addr=0x2000, STARVE_LIMIT=4 -> mem_gnt for 4 cycles, then if_gnt in the 5th cycle (PRI_IF), then mem_gnt again; responses carry the correct owner tags.
- MEM write 0xDEADBEEF to 0x2004, mode word, then MEM read of 0x2004 -> write cycle has ram_we=1 and no mem_rvalid; read returns mem_rdata=0xDEADBEEF one cycle after grant.
- IF granted in cycle N, if_kill=1 in cycle N+1 -> if_rvalid stays 0 in N+1; no IF grant in N+1; mem_gnt=1 in N+1 if mem_req is high.
- Drive reset low mid-stream with a read tag pending -> all outputs 0 immediately (asynchronous); after release, no stale rvalid; the counter restarts from 0.
- No requests for 10 cycles -> ram_en=0 and both gnt/rvalid stay 0 throughout.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port SRAM between instruction fetch and data access.
// Data wins conflicts; a starvation guard forces IF after STARVE_LIMIT losses.
module sram_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_kill,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  mem_mode,
  input  logic        mem_us,
  output logic        mem_gnt,
  output logic        mem_rvalid,
  output logic [31:0] mem_rdata,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [2:0]  ram_mode,
  output logic        ram_us,
  input  logic [31:0] ram_rdata
);

  typedef enum logic {
    PRI_MEM = 1'b0,
    PRI_IF  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [2:0] MODE_WORD = 3'b010;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tag_vld_q, tag_vld_d;
  logic             tag_if_q, tag_if_d;

  logic if_elig;
  logic mem_elig;

  // Reset low also masks requests so every output is 0 while held in reset.
  always_comb begin
    if_elig  = reset & if_req & ~if_kill;
    mem_elig = reset & mem_req;
    if_gnt   = if_elig & (~mem_elig | (state_q == PRI_IF));
    mem_gnt  = mem_elig & ~if_gnt;
  end

  always_comb begin
    ram_en    = if_gnt | mem_gnt;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_mode  = '0;
    ram_us    = 1'b0;
    unique case (1'b1)
      if_gnt: begin
        ram_addr = if_addr;
        ram_mode = MODE_WORD;
      end
      mem_gnt: begin
        ram_we    = mem_we;
        ram_addr  = mem_addr;
        ram_wdata = mem_wdata;
        ram_mode  = mem_mode;
        ram_us    = mem_us;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d   = '0;
    state_d = state_q;
    if (if_elig & mem_gnt) begin
      cnt_d = (cnt_q >= LIMIT) ? LIMIT : cnt_q + 1'b1;
    end
    unique case (state_q)
      PRI_MEM: begin
        if (cnt_d == LIMIT) state_d = PRI_IF;
      end
      PRI_IF: begin
        if (if_gnt | ~if_elig) begin
          state_d = PRI_MEM;
          cnt_d   = '0;
        end
      end
      default: state_d = PRI_MEM;
    endcase
  end

  always_comb begin
    tag_vld_d = if_gnt | (mem_gnt & ~mem_we);
    tag_if_d  = if_gnt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= PRI_MEM;
      cnt_q     <= '0;
      tag_vld_q <= 1'b0;
      tag_if_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tag_vld_q <= tag_vld_d;
      tag_if_q  <= tag_if_d;
    end
  end

  // Read data is a pass-through of the RAM port, steered by the tag.
  always_comb begin
    if_rvalid  = tag_vld_q & tag_if_q & ~if_kill;
    mem_rvalid = tag_vld_q & ~tag_if_q;
    if_rdata   = if_rvalid ? ram_rdata : '0;
    mem_rdata  = mem_rvalid ? ram_rdata : '0;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus random traffic
// checked each cycle against a loss-counting reference model.
module tb_sram_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_kill, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        mem_req, mem_we, mem_us, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_mode, ram_mode;
  logic        ram_en, ram_we, ram_us;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  sram_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mode(mem_mode), .mem_us(mem_us),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_mode(ram_mode), .ram_us(ram_us),
    .ram_rdata(ram_rdata)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [31:0] pat(int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  // SRAM device: 256 words, aliased by addr[9:2]; non-read cycles scramble rdata.
  logic [31:0] sram [0:255];
  initial begin
    for (int i = 0; i < 256; i++) sram[i] = pat(i);
    ram_rdata = '0;
    forever begin
      @(posedge clk);
      if (ram_en && ram_we) begin
        sram[ram_addr[9:2]] <= ram_wdata;
        ram_rdata <= $urandom;
      end else if (ram_en) begin
        ram_rdata <= sram[ram_addr[9:2]];
      end else begin
        ram_rdata <= $urandom;
      end
    end
  end

  // Reference model: IF wins a conflict only after losing LIMIT cycles in a row.
  logic [31:0] ref_mem [0:255];
  int          losses;
  bit          tv, towner_if;
  logic [31:0] tdata;
  bit          m_if_gnt, m_mem_gnt;

  initial begin
    bit ie, me, gi, gm;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    losses = 0; tv = 0; towner_if = 0; tdata = '0;
    m_if_gnt = 0; m_mem_gnt = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_mem_gnt", mem_gnt, 0);
        chk("rst_if_rvalid", if_rvalid, 0);
        chk("rst_mem_rvalid", mem_rvalid, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_ram_mode", ram_mode, 0);
        chk("rst_ram_us", ram_us, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        losses = 0; tv = 0; m_if_gnt = 0; m_mem_gnt = 0;
      end else begin
        ie = if_req && !if_kill;
        me = mem_req;
        gi = ie && (!me || losses >= LIMIT);
        gm = me && !gi;
        chk("if_gnt", if_gnt, gi);
        chk("mem_gnt", mem_gnt, gm);
        chk("ram_en", ram_en, gi || gm);
        chk("ram_we", ram_we, gm && mem_we);
        if (gi) begin
          chk("if_ram_addr", ram_addr, if_addr);
          chk("if_ram_mode", ram_mode, 3'b010);
          chk("if_ram_us", ram_us, 0);
        end
        if (gm) begin
          chk("mem_ram_addr", ram_addr, mem_addr);
          chk("mem_ram_mode", ram_mode, mem_mode);
          chk("mem_ram_us", ram_us, mem_us);
          if (mem_we) chk("mem_ram_wdata", ram_wdata, mem_wdata);
        end
        chk("if_rvalid", if_rvalid, tv && towner_if && !if_kill);
        chk("mem_rvalid", mem_rvalid, tv && !towner_if);
        if (tv && towner_if && !if_kill) chk("if_rdata", if_rdata, tdata);
        if (tv && !towner_if) chk("mem_rdata", mem_rdata, tdata);
        if (ie && gm) losses = (losses < LIMIT) ? losses + 1 : LIMIT;
        else losses = 0;
        tv = gi || (gm && !mem_we);
        towner_if = gi;
        tdata = gi ? ref_mem[if_addr[9:2]] : ref_mem[mem_addr[9:2]];
        if (gm && mem_we) ref_mem[mem_addr[9:2]] = mem_wdata;
        m_if_gnt = gi;
        m_mem_gnt = gm;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk); #1;
  endtask

  initial begin
    logic [5:0] gp;
    logic [4:0] gp2;
    reset = 0; if_req = 0; if_addr = 0; if_kill = 0;
    mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0;
    mem_mode = 0; mem_us = 0;
    gp = '0; gp2 = '0;
    repeat (3) step();

    reset = 1; if_req = 1; if_addr = 32'h100;
    look();
    chk("t1_if_gnt", if_gnt, 1);
    chk("t1_ram_en", ram_en, 1);
    chk("t1_ram_addr", ram_addr, 32'h100);
    chk("t1_ram_we", ram_we, 0);
    step(); if_req = 0;
    look();
    chk("t1_if_rvalid", if_rvalid, 1);
    chk("t1_if_rdata", if_rdata, 32'hA500_0040);
    chk("t1_mem_rvalid", mem_rvalid, 0);

    step();
    if_req = 1; if_addr = 32'h104;
    mem_req = 1; mem_we = 0; mem_addr = 32'h2000; mem_mode = 3'b010;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      look();
      gp[i] = if_gnt;
      if (i == 5) begin
        chk("st_if_rvalid", if_rvalid, 1);
        chk("st_if_rdata", if_rdata, 32'hA500_0041);
        chk("st_mem_rvalid", mem_rvalid, 0);
      end
    end
    chk("starve_pattern", gp, 6'b010000);

    step();
    if_req = 0; mem_we = 1; mem_addr = 32'h2004; mem_wdata = 32'hDEAD_BEEF;
    look();
    chk("wr_mem_gnt", mem_gnt, 1);
    chk("wr_ram_we", ram_we, 1);
    step(); mem_we = 0;
    look();
    chk("wr_no_rvalid", mem_rvalid, 0);
    chk("rd_ram_we", ram_we, 0);
    step(); mem_req = 0;
    look();
    chk("rd_mem_rvalid", mem_rvalid, 1);
    chk("rd_mem_rdata", mem_rdata, 32'hDEAD_BEEF);

    step(); if_req = 1; if_addr = 32'h108;
    look();
    chk("kl_if_gnt0", if_gnt, 1);
    step();
    if_addr = 32'h10C; if_kill = 1;
    mem_req = 1; mem_we = 0; mem_addr = 32'h200;
    look();
    chk("kl_if_rvalid", if_rvalid, 0);
    chk("kl_if_gnt", if_gnt, 0);
    chk("kl_mem_gnt", mem_gnt, 1);
    step(); if_kill = 0; mem_req = 0;
    look();
    chk("kl_if_gnt2", if_gnt, 1);
    chk("kl_mem_rvalid", mem_rvalid, 1);
    chk("kl_mem_rdata", mem_rdata, 32'hA500_0080);

    step(); mem_req = 1; mem_addr = 32'h2000;
    look();
    chk("rs_mem_gnt", mem_gnt, 1);
    step(); reset = 0; #1;
    chk("rs_async_mem_rvalid", mem_rvalid, 0);
    chk("rs_async_if_gnt", if_gnt, 0);
    chk("rs_async_mem_gnt", mem_gnt, 0);
    chk("rs_async_ram_en", ram_en, 0);
    chk("rs_async_ram_addr", ram_addr, 0);
    look();
    step(); reset = 1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      look();
      gp2[i] = if_gnt;
      if (i == 0) begin
        chk("rs_stale_mem_rvalid", mem_rvalid, 0);
        chk("rs_stale_if_rvalid", if_rvalid, 0);
      end
    end
    chk("rs_starve_pattern", gp2, 5'b10000);

    step(); if_req = 0; mem_req = 0;
    for (int i = 0; i < 10; i++) begin
      step(); look();
      chk("idle_ram_en", ram_en, 0);
      chk("idle_gnt", {if_gnt, mem_gnt}, 0);
      chk("idle_rvalid", {if_rvalid, mem_rvalid}, 0);
    end

    for (int c = 0; c < 3000; c++) begin
      step();
      if (!if_req || m_if_gnt) begin
        if_req = ($urandom_range(0, 3) != 0);
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!mem_req || m_mem_gnt) begin
        mem_req = ($urandom_range(0, 3) != 0);
        mem_we = $urandom_range(0, 1);
        mem_addr = $urandom & 32'hFFFF_FFFC;
        mem_wdata = $urandom;
        mem_mode = 3'($urandom_range(0, 7));
        mem_us = $urandom_range(0, 1);
      end
      if_kill = ($urandom_range(0, 7) == 0);
    end
    step(); if_req = 0; mem_req = 0; if_kill = 0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
